ahblite_sram_slave: RTL and testbench

//  AHB-Lite responder fronting a word-organised single-port SRAM; target of the core's dbus/ibus masters.

---
 rtl/ahblite_sram_if.sv | 35 +++
 rtl/ahblite_sram_slave.sv | 186 ++++++++++++++++++
 tb/tb_ahblite_sram_slave.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ahblite_sram_if.sv
// ============================================================================
// Module   : ahblite_sram_if
// Brief    : AHB-Lite bus bundle between a master/interconnect and the SRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ahblite_sram_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

`default_nettype wire

// File: rtl/ahblite_sram_slave.sv
// ============================================================================
// Module   : ahblite_sram_slave
// Brief    : AHB-Lite responder for a word-organised SRAM with wait states, a
//            1-entry pending-write buffer and store-to-load forwarding.
//            Define AHBLITE_SRAM_ERR_EN to enable the ERROR response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahblite_sram_slave #(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ahblite_sram_if.slave    bus
);

  localparam int         c_depth = 2 ** (AW - 2);
  localparam logic [2:0] c_wait  = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  logic [DW-1:0] r_mem [c_depth];

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic          r_hreadyout;
  logic          r_hresp;
  logic [DW-1:0] r_hrdata;

  logic          r_dp_act;
  logic          r_dp_write;
  logic [AW-3:0] r_dp_addr;
  logic [3:0]    r_dp_be;

  logic          r_pend_vld;
  logic [AW-3:0] r_pend_addr;
  logic [3:0]    r_pend_be;
  logic [DW-1:0] r_pend_data;

  logic          w_accept;
  logic          w_err;
  logic          w_go;
  logic          w_rd_go;
  logic          w_wr_done;
  logic          w_commit;
  logic [AW-3:0] w_word;
  logic [3:0]    w_be;
  logic [DW-1:0] w_fwd;
  logic          w_unused;

  assign w_accept = bus.hsel & bus.htrans[1] & bus.hready;
  assign w_word   = bus.haddr[AW-1:2];

`ifdef AHBLITE_SRAM_ERR_EN
  assign w_err = (bus.hsize == 3'd1 && bus.haddr[0]) ||
                 (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00) ||
                 (bus.hsize > 3'd2);
  assign bus.hresp = r_hresp;
  assign w_unused  = ^bus.hburst;
`else
  assign w_err     = 1'b0;
  assign bus.hresp = 1'b0;
  assign w_unused  = ^{bus.hburst, r_hresp};
`endif

  // Strobes ignore the low address bits the size does not use, which also
  // masks misaligned addresses when no ERROR response is generated.
  always_comb begin
    w_be = 4'b1111;
    case (bus.hsize)
      3'd0:    w_be = 4'b0001 << bus.haddr[1:0];
      3'd1:    w_be = bus.haddr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_go      = w_accept & ~w_err;
  assign w_rd_go   = w_go & ~bus.hwrite;
  assign w_wr_done = r_dp_act & r_dp_write & r_hreadyout;
  // The buffer drains on any edge without a read, or when a newer write displaces it.
  assign w_commit  = r_pend_vld & (~w_rd_go | w_wr_done);

  // Newest data wins: SRAM, then the buffered write, then the write completing now.
  always_comb begin
    w_fwd = r_mem[w_word];
    for (int i = 0; i < 4; i++) begin
      if (r_pend_vld && r_pend_addr == w_word && r_pend_be[i])
        w_fwd[8*i +: 8] = r_pend_data[8*i +: 8];
      if (w_wr_done && r_dp_addr == w_word && r_dp_be[i])
        w_fwd[8*i +: 8] = bus.hwdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++)
        if (r_pend_be[i]) r_mem[r_pend_addr][8*i +: 8] <= r_pend_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_dp_act    <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_addr   <= '0;
      r_dp_be     <= 4'b0000;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_be   <= 4'b0000;
      r_pend_data <= '0;
    end else begin
      if (w_wr_done) begin
        r_pend_vld  <= 1'b1;
        r_pend_addr <= r_dp_addr;
        r_pend_be   <= r_dp_be;
        r_pend_data <= bus.hwdata;
      end else if (w_commit) begin
        r_pend_vld <= 1'b0;
      end

      if (r_hreadyout) r_dp_act <= 1'b0;
      if (w_rd_go)     r_hrdata <= w_fwd;

      case (r_state)
        S_IDLE, S_ERR2: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
          if (w_accept) begin
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else begin
              r_dp_act   <= 1'b1;
              r_dp_write <= bus.hwrite;
              r_dp_addr  <= w_word;
              r_dp_be    <= w_be;
              if (c_wait != 3'd0) begin
                r_state     <= S_WAIT;
                r_cnt       <= c_wait;
                r_hreadyout <= 1'b0;
              end
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hreadyout = r_hreadyout;
  assign bus.hrdata    = r_hrdata;

endmodule

`default_nettype wire

// File: tb/tb_ahblite_sram_slave.sv
// ============================================================================
// Module   : tb_ahblite_sram_slave
// Brief    : Directed vector bench for ahblite_sram_slave at WAIT_CYCLES 0, 2 and 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahblite_sram_slave;

  localparam int AW = 16;

  typedef struct {
    int          id;
    int          dut;
    bit          wr;
    logic [2:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          waits;
    bit          resp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cur = 0;
  logic        m_hsel   = 1'b0;
  logic [15:0] m_haddr  = '0;
  logic [1:0]  m_htrans = 2'b00;
  logic        m_hwrite = 1'b0;
  logic [2:0]  m_hsize  = 3'd0;
  logic [31:0] m_hwdata = '0;

  logic        hro_a  [3];
  logic        hresp_a[3];
  logic [31:0] rdata_a[3];

  int n_chk  = 0;
  int n_pass = 0;

  vec_t vecs[16];
  vec_t idle_v;
  vec_t p;
  bit   p_vld = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahblite_sram_if #(.AW(AW), .DW(32)) bus ();
    assign bus.hsel   = m_hsel & (cur == g);
    assign bus.haddr  = m_haddr;
    assign bus.htrans = (cur == g) ? m_htrans : 2'b00;
    assign bus.hwrite = m_hwrite;
    assign bus.hsize  = m_hsize;
    assign bus.hburst = 3'b000;
    assign bus.hwdata = m_hwdata;
    assign bus.hready = bus.hreadyout;
    assign hro_a[g]   = bus.hreadyout;
    assign hresp_a[g] = bus.hresp;
    assign rdata_a[g] = bus.hrdata;

    ahblite_sram_slave #(
      .AW(AW), .DW(32), .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input int dut, input bit wr, input logic [2:0] size,
                              input logic [15:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp, input int waits, input bit resp);
    vec_t v;
    v.id = 0; v.dut = dut; v.wr = wr; v.size = size; v.addr = addr;
    v.wdata = wdata; v.exp = exp; v.waits = waits; v.resp = resp;
    return v;
  endfunction

  // One bus cycle group: present v's address phase plus the previous data
  // phase, wait for the previous transfer to complete, check it, then clock.
  task automatic step(input bit have, input vec_t v);
    int stalls = 0;
    m_hsel   = have;
    m_htrans = have ? 2'b10 : 2'b00;
    m_haddr  = v.addr;
    m_hwrite = v.wr;
    m_hsize  = v.size;
    m_hwdata = (p_vld && p.wr) ? p.wdata : 32'h0;
    @(negedge clk);
    while (hro_a[cur] !== 1'b1) begin
      if (p_vld) check($sformatf("v%0d stall hresp", p.id), 32'(hresp_a[cur]), 32'(p.resp));
      stalls++;
      if (stalls > 16) begin
        check($sformatf("v%0d hreadyout timeout", p.id), 32'(hro_a[cur]), 32'd1);
        break;
      end
      @(negedge clk);
    end
    if (p_vld) begin
      check($sformatf("v%0d wait states", p.id), 32'(stalls), 32'(p.waits));
      check($sformatf("v%0d hresp", p.id), 32'(hresp_a[cur]), 32'(p.resp));
      if (!p.wr) check($sformatf("v%0d hrdata", p.id), rdata_a[cur], p.exp);
    end
    @(posedge clk);
    #1;
    p     = v;
    p_vld = have;
  endtask

  initial begin
    idle_v = mk(0, 1'b0, 3'd0, 16'h0, 32'h0, 32'h0, 0, 1'b0);
    p      = idle_v;

    vecs[0]  = mk(0, 1'b1, 3'd2, 16'h0100, 32'hDEADBEEF, 32'h0,        0, 1'b0);
    vecs[1]  = mk(0, 1'b0, 3'd2, 16'h0100, 32'h0,        32'hDEADBEEF, 0, 1'b0);
    vecs[2]  = mk(0, 1'b1, 3'd2, 16'h0200, 32'h11223344, 32'h0,        0, 1'b0);
    vecs[3]  = mk(0, 1'b1, 3'd0, 16'h0201, 32'h0000AA00, 32'h0,        0, 1'b0);
    vecs[4]  = mk(0, 1'b0, 3'd2, 16'h0200, 32'h0,        32'h1122AA44, 0, 1'b0);
    vecs[5]  = mk(0, 1'b1, 3'd2, 16'h0300, 32'h00000000, 32'h0,        0, 1'b0);
    vecs[6]  = mk(0, 1'b1, 3'd1, 16'h0302, 32'hBEEF0000, 32'h0,        0, 1'b0);
    vecs[7]  = mk(0, 1'b0, 3'd2, 16'h0300, 32'h0,        32'hBEEF0000, 0, 1'b0);
`ifdef AHBLITE_SRAM_ERR_EN
    vecs[8]  = mk(0, 1'b1, 3'd1, 16'h0103, 32'h55550000, 32'h0,        1, 1'b1);
    vecs[9]  = mk(0, 1'b0, 3'd2, 16'h0100, 32'h0,        32'hDEADBEEF, 0, 1'b0);
`else
    vecs[8]  = mk(0, 1'b1, 3'd1, 16'h0103, 32'h55550000, 32'h0,        0, 1'b0);
    vecs[9]  = mk(0, 1'b0, 3'd2, 16'h0100, 32'h0,        32'h5555BEEF, 0, 1'b0);
`endif
    vecs[10] = mk(0, 1'b0, 3'd0, 16'h0203, 32'h0,        32'h1122AA44, 0, 1'b0);
    vecs[11] = mk(1, 1'b1, 3'd2, 16'h0100, 32'hCAFEF00D, 32'h0,        2, 1'b0);
    vecs[12] = mk(1, 1'b0, 3'd2, 16'h0100, 32'h0,        32'hCAFEF00D, 2, 1'b0);
    vecs[13] = mk(1, 1'b0, 3'd1, 16'h0102, 32'h0,        32'hCAFEF00D, 2, 1'b0);
    vecs[14] = mk(2, 1'b1, 3'd2, 16'h0400, 32'h0BADF00D, 32'h0,        3, 1'b0);
    vecs[15] = mk(2, 1'b0, 3'd2, 16'h0400, 32'h0,        32'h0BADF00D, 3, 1'b0);
    for (int i = 0; i < 16; i++) vecs[i].id = i;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset hreadyout d%0d", k), 32'(hro_a[k]), 32'd1);
      check($sformatf("reset hresp d%0d", k), 32'(hresp_a[k]), 32'd0);
      check($sformatf("reset hrdata d%0d", k), rdata_a[k], 32'h0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].dut != cur) begin
        if (p_vld) step(1'b0, idle_v);
        cur = vecs[i].dut;
      end
      step(1'b1, vecs[i]);
    end
    step(1'b0, idle_v);
    step(1'b0, idle_v);

    // Reset during the wait states of a write to 0x0400 on the 3-wait instance.
    step(1'b1, mk(2, 1'b1, 3'd2, 16'h0400, 32'h12345678, 32'h0, 3, 1'b0));
    m_hsel   = 1'b0;
    m_htrans = 2'b00;
    m_hwdata = 32'h12345678;
    @(negedge clk);
    check("rst-mid hreadyout before", 32'(hro_a[2]), 32'd0);
    check("rst-mid hrdata held", rdata_a[2], 32'h0BADF00D);
    #2 rst = 1'b1;
    #1;
    check("rst-mid hreadyout", 32'(hro_a[2]), 32'd1);
    check("rst-mid hresp", 32'(hresp_a[2]), 32'd0);
    check("rst-mid hrdata", rdata_a[2], 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    p_vld = 1'b0;
    step(1'b1, mk(2, 1'b0, 3'd2, 16'h0400, 32'h0, 32'h0BADF00D, 3, 1'b0));
    step(1'b0, idle_v);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
